// File: rtl/macro_feed_fifo.sv
// macro_feed_fifo: circular-buffer input FIFO that feeds the macro's aap/banaan
// interface. The head word is held in an output register, and status flags are
// registered from the next occupancy.
// Optional feature: define MACRO_FEED_LEVEL_EN to add the registered `level` port.
module macro_feed_fifo #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 8,
    parameter int AFULL_THR = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     aap,
    output logic [WIDTH-1:0]         banaan,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
`ifdef MACRO_FEED_LEVEL_EN
    output logic                     afull,
    output logic [$clog2(DEPTH):0]   level
`else
    output logic                     afull
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_THR);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             aap_q, aap_d;
    logic [WIDTH-1:0] banaan_q, banaan_d, head_word;
    logic             full_q, full_d, empty_q, empty_d, afull_q, afull_d;
`ifdef MACRO_FEED_LEVEL_EN
    logic [CW-1:0]    level_q, level_d;
`endif
    logic             push, pop;

    // A word in the output register always counts as occupied, so aap_q implies cnt_q > 0.
    assign push = in_valid && !full_q;
    assign pop  = aap_q && out_ready;

    // Pointer and occupancy update; clr wins over any push/pop in the same cycle.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + PTR_ONE;
        if (pop)  rp_d = rp_q + PTR_ONE;
        if (push && !pop)
            cnt_d = cnt_q + CNT_ONE;
        else if (pop && !push)
            cnt_d = cnt_q - CNT_ONE;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    // Next head word: bypass the incoming word when it lands in the slot that becomes the head.
    always_comb begin
        head_word = (push && (wp_q == rp_d)) ? in_data : mem_q[rp_d];
        aap_d     = (cnt_d != '0);
        banaan_d  = aap_d ? head_word : banaan_q;
        full_d    = (cnt_d == CNT_FULL);
        empty_d   = (cnt_d == '0);
        afull_d   = (cnt_d >= CNT_AFULL);
`ifdef MACRO_FEED_LEVEL_EN
        level_d   = cnt_d;
`endif
    end

    // Storage array; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= in_data;
    end

    // Control, head and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            aap_q    <= 1'b0;
            banaan_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
`ifdef MACRO_FEED_LEVEL_EN
            level_q  <= '0;
`endif
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            aap_q    <= aap_d;
            banaan_q <= banaan_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
`ifdef MACRO_FEED_LEVEL_EN
            level_q  <= level_d;
`endif
        end
    end

    assign in_ready = !full_q;
    assign aap      = aap_q;
    assign banaan   = banaan_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign afull    = afull_q;
`ifdef MACRO_FEED_LEVEL_EN
    assign level    = level_q;
`endif

endmodule

// File: tb/tb_macro_feed_fifo.sv
// Directed self-checking bench for macro_feed_fifo (WIDTH=3, DEPTH=8, AFULL_THR=6).
module tb_macro_feed_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       aap;
    logic [2:0] banaan;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic       afull;
`ifdef MACRO_FEED_LEVEL_EN
    logic [3:0] level;
`endif

    int errors = 0;
    int checks = 0;

    macro_feed_fifo #(.WIDTH(3), .DEPTH(8), .AFULL_THR(6)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .aap(aap), .banaan(banaan), .out_ready(out_ready),
        .full(full), .empty(empty),
`ifdef MACRO_FEED_LEVEL_EN
        .afull(afull), .level(level)
`else
        .afull(afull)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_level(input string tag, input int exp);
`ifdef MACRO_FEED_LEVEL_EN
        check(tag, 32'(level), 32'(exp));
`endif
    endtask

    logic [2:0] drain_exp [8];
    logic [2:0] d;

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_aap", 32'(aap), 0);
        check("rst_banaan", 32'(banaan), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_full", 32'(full), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_afull", 32'(afull), 0);
        check_level("rst_level", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push with the macro stalled: 1-cycle latency, then held.
        in_valid = 1'b1; in_data = 3'h5;
        tick();
        in_valid = 1'b0;
        check("push1_aap", 32'(aap), 1);
        check("push1_banaan", 32'(banaan), 5);
        check("push1_empty", 32'(empty), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_banaan", 32'({aap, banaan}), 32'h0D);
        end

        // Flush the held word.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr1_empty", 32'(empty), 1);
        check("clr1_aap", 32'(aap), 0);

        // Fill 0..7 with out_ready low.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 3'(i);
            tick();
            check("fill_afull", 32'(afull), 32'(i + 1 >= 6));
            check("fill_full", 32'(full), 32'(i + 1 == 8));
            check("fill_in_ready", 32'(in_ready), 32'(i + 1 < 8));
            check("fill_head", 32'(banaan), 0);
        end
        // Ninth word is refused.
        in_data = 3'h6;
        tick();
        check("ninth_full", 32'(full), 1);
        check("ninth_in_ready", 32'(in_ready), 0);
        check_level("ninth_level", 8);
        // Pop one from full with in_valid high: no push in that cycle.
        out_ready = 1'b1;
        tick();
        check("popfull_in_ready", 32'(in_ready), 1);
        check("popfull_banaan", 32'(banaan), 1);
        check("popfull_afull", 32'(afull), 1);
        check_level("popfull_level", 7);
        out_ready = 1'b0;
        tick();
        check("refill_full", 32'(full), 1);
        in_valid = 1'b0; out_ready = 1'b1;
        drain_exp = '{3'h1, 3'h2, 3'h3, 3'h4, 3'h5, 3'h6, 3'h7, 3'h6};
        for (int i = 0; i < 8; i++) begin
            check("drain_data", 32'({aap, banaan}), 32'({1'b1, drain_exp[i]}));
            tick();
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_aap", 32'(aap), 0);

        // Sustained streaming across pointer wrap.
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            d = 3'((k * 3 + 1) % 8);
            in_data = d;
            tick();
            check("stream_data", 32'({aap, banaan}), 32'({1'b1, d}));
            check("stream_full", 32'({full, empty}), 0);
            check_level("stream_level", 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_empty", 32'(empty), 1);

        // Fill 4, then clr while presenting a word.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 3'(i);
            tick();
        end
        check("fill4_head", 32'(banaan), 1);
        check_level("fill4_level", 4);
        clr = 1'b1; in_data = 3'h7;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_empty", 32'(empty), 1);
        check("clr_aap", 32'(aap), 0);
        check("clr_in_ready", 32'(in_ready), 1);
        check_level("clr_level", 0);
        tick();
        check("clr_dropped", 32'({aap, empty}), 32'h1);
        in_valid = 1'b1; in_data = 3'h3;
        tick();
        in_valid = 1'b0;
        check("post_clr_push", 32'({aap, banaan}), 32'h0B);

        // Fill to full, then asynchronous reset between edges.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 3'(7 - i);
            tick();
        end
        in_valid = 1'b1; in_data = 3'h2;
        check("prerst_full", 32'(full), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_aap", 32'(aap), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_empty", 32'(empty), 1);
        check("arst_banaan", 32'(banaan), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 3'h2;
        tick();
        in_valid = 1'b0;
        check("postrst_push", 32'({aap, banaan}), 32'h0A);
        check("postrst_flags", 32'({full, empty, afull}), 0);
        check_level("postrst_level", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/macro_feed_fifo.md
# macro_feed_fifo

Input buffer that sits directly upstream of the macro wrapper: it accepts 3-bit words from the producer over a valid/ready handshake and presents them to the macro's `aap` strobe and `banaan` bus at full throughput. It absorbs producer bursts and macro back-pressure, and exposes full/empty/almost-full status to the surrounding control logic.

## Interface
- `WIDTH`, 3, data word width (matches the macro `banaan` bus)
- `DEPTH`, 8, number of storage entries; a power of 2, minimum 2
- `AFULL_THR`, 6, occupancy at or above which `afull` asserts; range 1..DEPTH
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `clr`  in  1  synchronous flush; discards all entries
- `in_valid`  in  1  producer word valid
- `in_ready`  out  1  space available; equals !full
- `in_data`  in  WIDTH  producer word
- `aap`  out  1  head word valid to the macro
- `banaan`  out  WIDTH  head word to the macro, registered
- `out_ready`  in  1  macro accepts the head word
- `full`  out  1  occupancy == DEPTH
- `empty`  out  1  occupancy == 0
- `afull`  out  1  occupancy >= AFULL_THR
- `level`  out  $clog2(DEPTH)+1  occupancy; present only with MACRO_FEED_LEVEL_EN

## Operation
- Storage is a circular buffer with write pointer `wp`, read pointer `rp`, and occupancy counter `cnt`. `wp` and `rp` are $clog2(DEPTH) bits wide and wrap modulo DEPTH. `cnt` is $clog2(DEPTH)+1 bits wide.
- Push: `in_valid && in_ready` at a clock edge. The word is written at `wp` and `wp` increments.
- Pop: `aap && out_ready` at a clock edge. `rp` increments.
- `cnt` next value: +1 on push only, -1 on pop only, unchanged on both or on neither.
- The head word is held in an output register. `banaan` never changes while `aap && !out_ready`.
- When not popped, `aap` and `banaan` stay stable until accepted (AXI-style hold rule).
- Push while full is impossible (`in_ready`=0), including when a pop happens in the same cycle. There is no full-bypass.
- Pop while empty is impossible (`aap`=0).
- Status flags are registered and derived from the next value of `cnt`, so they are valid in the same cycle as the pointers they describe.
- `clr`: in the next cycle `wp`=`rp`=`cnt`=0 and `aap`=0. `clr` overrides any push or pop in the same cycle; words presented in that cycle are dropped.
- Reset (async assert, any cycle, including mid-burst): `wp`=`rp`=`cnt`=0. Outputs take their reset values immediately. Stored contents become don't-care.
- Reset values: `aap`=0, `banaan`=0, `in_ready`=1, `full`=0, `empty`=1, `afull`=0, `level`=0.

## Timing
- Write-to-head latency into an empty FIFO is 1 cycle. A word pushed at edge N drives `aap`=1 with `banaan`=word after edge N.
- Throughput is one word per cycle sustained with `in_valid`=`out_ready`=1. There are no bubbles at wrap-around or at the empty/non-empty transition.
- `in_ready` rises one cycle after the pop that frees a slot from full.
- `rst_n` deassertion must be synchronous to `clk` externally. The first push is accepted at the first edge after deassertion.

## Configuration
- `MACRO_FEED_LEVEL_EN` defined: the `level` port exists and is driven from `cnt`, registered.
- `MACRO_FEED_LEVEL_EN` not defined: `level` is absent from the port list. Only `full`, `empty` and `afull` are provided. Functional behaviour is otherwise identical.

## Test plan
- Reset, then push 0x5 with `out_ready`=0 -> next cycle `aap`=1, `banaan`=0x5, `empty`=0; the value is held for 10 cycles.
- Push 8 words 0..7 with `out_ready`=0 -> `afull`=1 after the 6th push and `full`=1, `in_ready`=0 after the 8th. A 9th `in_valid` is not accepted.
- From full, pulse `out_ready` for 1 cycle while `in_valid`=1 with 0x6 -> no push that cycle. `in_ready`=1 the next cycle, and 0x6 is accepted then.
- Stream 20 words with `in_valid`=`out_ready`=1 -> `banaan` sequence equals the input sequence, one per cycle, with no gaps across the pointer wrap; `cnt` stays at 1.
- Fill with 4 words, assert `clr` with `in_valid`=1 -> next cycle `empty`=1, `aap`=0, and `level`=0 (LEVEL_EN build). The word presented in that cycle is lost.
- Assert `rst_n`=0 mid-stream between edges -> `aap`=0, `in_ready`=1, `empty`=1 immediately. After release, the FIFO behaves as freshly reset.
